// File: rtl/npc_halt_pkg.sv
// Shared definitions for the NPC simulation-termination sequencer.
//   EBREAK_INST : encoding of the EBREAK instruction watched on the commit stream
//   state_t     : sequencer states (RUN, DRAIN, HALTED)
//   reason_t    : halt reason reported to the sim wrapper
package npc_halt_pkg;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        GOOD_TRAP = 2'd1,
        BAD_TRAP  = 2'd2,
        TIMEOUT   = 2'd3
    } reason_t;

endpackage

// File: rtl/halt_inflight_cnt.sv
// Saturating up/down counter of instructions in flight.
//   clock, reset : clock and asynchronous active-high reset
//   issue        : an instruction entered the pipeline this cycle
//   issue_block  : fetch is stalled, so issue is ignored
//   commit       : an instruction left the pipeline this cycle
//   zero_next    : the count after this cycle's update is zero
// The count saturates at 2^INFL_W-1 and holds at 0 on an extra commit.
module halt_inflight_cnt #(
    parameter int INFL_W = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic issue,
    input  logic issue_block,
    input  logic commit,
    output logic zero_next
);

    localparam logic [INFL_W-1:0] CNT_MAX = '1;

    logic [INFL_W-1:0] cnt_reg;
    logic [INFL_W-1:0] cnt_next;
    logic              issue_eff;

    always_comb begin
        issue_eff = issue & ~issue_block;
        cnt_next  = cnt_reg;
        // Issue and commit together cancel out, so only the lone cases move the count.
        if (issue_eff && !commit) begin
            if (cnt_reg != CNT_MAX) begin
                cnt_next = cnt_reg + INFL_W'(1);
            end
        end else if (!issue_eff && commit) begin
            if (cnt_reg != '0) begin
                cnt_next = cnt_reg - INFL_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Looking at the post-update value lets DRAIN exit in the same cycle the
    // last outstanding instruction commits.
    assign zero_next = (cnt_next == '0);

endmodule

// File: rtl/halt_ctrl.sv
// Simulation-termination sequencer for the NPC core.
// On an EBREAK commit it latches the trap PC and a0, stalls fetch, flushes
// once, drains in-flight instructions and then raises a one-cycle halt pulse
// followed by a sticky halted level. Also keeps cycle and instret counters.
// Ports:
//   clock, reset      : clock and asynchronous active-high reset
//   issue_fire        : instruction entered the pipeline
//   commit_valid/inst/pc : commit stream
//   a0_value          : architectural a0, latched as the exit code
//   fetch_stall, flush: pipeline control
//   halt_pulse, halted, halt_reason, halt_pc, halt_code : halt report
//   cycle_cnt, instret_cnt : end-of-run statistics
// Optional build macro HALT_CTRL_WATCHDOG_EN adds a commit-idle watchdog that
// halts with reason TIMEOUT after WDOG_CYCLES commit-free RUN cycles.
module halt_ctrl
    import npc_halt_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int CNT_W       = 64,
    parameter int INFL_W      = 3,
    parameter int DRAIN_MAX   = 16,
    parameter int WDOG_CYCLES = 1000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_fire,
    input  logic             commit_valid,
    input  logic [31:0]      commit_inst,
    input  logic [XLEN-1:0]  commit_pc,
    input  logic [XLEN-1:0]  a0_value,
    output logic             fetch_stall,
    output logic             flush,
    output logic             halt_pulse,
    output logic             halted,
    output logic [1:0]       halt_reason,
    output logic [XLEN-1:0]  halt_pc,
    output logic [XLEN-1:0]  halt_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int DRAIN_W = $clog2(DRAIN_MAX + 1);

    state_t              state_reg;
    reason_t             reason_reg;
    logic                flush_reg;
    logic                halt_pulse_reg;
    logic [XLEN-1:0]     halt_pc_reg;
    logic [XLEN-1:0]     halt_code_reg;
    logic [CNT_W-1:0]    cycle_cnt_reg;
    logic [CNT_W-1:0]    instret_cnt_reg;
    logic [DRAIN_W-1:0]  drain_cnt_reg;
    logic                infl_zero_next;
    logic                wdog_fire;

    assign fetch_stall = (state_reg != RUN);

    halt_inflight_cnt #(
        .INFL_W (INFL_W)
    ) u_inflight (
        .clock       (clock),
        .reset       (reset),
        .issue       (issue_fire),
        .issue_block (fetch_stall),
        .commit      (commit_valid),
        .zero_next   (infl_zero_next)
    );

`ifdef HALT_CTRL_WATCHDOG_EN
    localparam int IDLE_W = $clog2(WDOG_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt_reg;

    // Fires on the WDOG_CYCLES-th consecutive commit-free RUN cycle.
    assign wdog_fire = (state_reg == RUN) && !commit_valid &&
                       (idle_cnt_reg == IDLE_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_cnt_reg <= '0;
        end else if (commit_valid || (state_reg != RUN)) begin
            idle_cnt_reg <= '0;
        end else begin
            idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
        end
    end
`else
    logic unused_wdog;

    assign wdog_fire   = 1'b0;
    assign unused_wdog = (WDOG_CYCLES != 0);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= RUN;
            reason_reg      <= NONE;
            flush_reg       <= 1'b0;
            halt_pulse_reg  <= 1'b0;
            halt_pc_reg     <= '0;
            halt_code_reg   <= '0;
            cycle_cnt_reg   <= '0;
            instret_cnt_reg <= '0;
            drain_cnt_reg   <= '0;
        end else begin
            flush_reg      <= 1'b0;
            halt_pulse_reg <= 1'b0;
            if (state_reg != HALTED) begin
                cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
            end
            case (state_reg)
                RUN: begin
                    drain_cnt_reg <= '0;
                    if (commit_valid) begin
                        instret_cnt_reg <= instret_cnt_reg + CNT_W'(1);
                        if (commit_inst == EBREAK_INST) begin
                            halt_pc_reg   <= commit_pc;
                            halt_code_reg <= a0_value;
                            flush_reg     <= 1'b1;
                            state_reg     <= DRAIN;
                        end
                    end else if (wdog_fire) begin
                        halt_pc_reg    <= '0;
                        halt_code_reg  <= '0;
                        reason_reg     <= TIMEOUT;
                        halt_pulse_reg <= 1'b1;
                        state_reg      <= HALTED;
                    end
                end
                DRAIN: begin
                    // Commits here are squashed: no instret, no EBREAK re-trigger.
                    drain_cnt_reg <= drain_cnt_reg + DRAIN_W'(1);
                    if (infl_zero_next) begin
                        reason_reg     <= (halt_code_reg == '0) ? GOOD_TRAP : BAD_TRAP;
                        halt_pulse_reg <= 1'b1;
                        state_reg      <= HALTED;
                    end else if (drain_cnt_reg == DRAIN_W'(DRAIN_MAX - 1)) begin
                        reason_reg     <= TIMEOUT;
                        halt_pulse_reg <= 1'b1;
                        state_reg      <= HALTED;
                    end
                end
                default: begin
                    // HALTED is sticky until reset.
                end
            endcase
        end
    end

    assign flush       = flush_reg;
    assign halt_pulse  = halt_pulse_reg;
    assign halted      = (state_reg == HALTED);
    assign halt_reason = reason_reg;
    assign halt_pc     = halt_pc_reg;
    assign halt_code   = halt_code_reg;
    assign cycle_cnt   = cycle_cnt_reg;
    assign instret_cnt = instret_cnt_reg;

endmodule

// File: tb/tb_halt_ctrl.sv
// Scoreboard bench for halt_ctrl: the stimulus side runs a cycle-level
// reference of the halt rules and queues the expected flush and halt events;
// a negedge monitor pops and compares whenever the DUT pulses flush/halt.
module tb_halt_ctrl;

    localparam int          XLEN      = 64;
    localparam int          CNT_W     = 64;
    localparam int          INFL_MAX  = 7;
    localparam int          DRAIN_MAX = 16;
    localparam int          WDOG      = 100;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             issue_fire = 1'b0;
    logic             commit_valid = 1'b0;
    logic [31:0]      commit_inst = '0;
    logic [XLEN-1:0]  commit_pc = '0;
    logic [XLEN-1:0]  a0_value = '0;
    logic             fetch_stall, flush, halt_pulse, halted;
    logic [1:0]       halt_reason;
    logic [XLEN-1:0]  halt_pc, halt_code;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;

    halt_ctrl #(
        .XLEN        (XLEN),
        .CNT_W       (CNT_W),
        .INFL_W      (3),
        .DRAIN_MAX   (DRAIN_MAX),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .issue_fire   (issue_fire),
        .commit_valid (commit_valid),
        .commit_inst  (commit_inst),
        .commit_pc    (commit_pc),
        .a0_value     (a0_value),
        .fetch_stall  (fetch_stall),
        .flush        (flush),
        .halt_pulse   (halt_pulse),
        .halted       (halted),
        .halt_reason  (halt_reason),
        .halt_pc      (halt_pc),
        .halt_code    (halt_code),
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          when_edge;
        logic [1:0]  reason;
        logic [63:0] pc;
        logic [63:0] code;
        logic [63:0] instret;
        logic [63:0] cycles;
    } halt_exp_t;

    halt_exp_t halt_q[$];
    int        flush_q[$];
    int        checks = 0;
    int        errors = 0;
    int        since_rst = 0;

    // Reference model: phase 0 running, 1 draining, 2 halted.
    int          m_phase, m_infl, m_cycles, m_instret, m_drain, m_idle;
    logic [63:0] m_pc, m_code;
    logic [1:0]  m_reason;

    always @(posedge clock or posedge reset) begin
        if (reset) since_rst <= 0;
        else       since_rst <= since_rst + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, since_rst);
        end
    endtask

    function automatic int clamp(input int v);
        if (v < 0) return 0;
        if (v > INFL_MAX) return INFL_MAX;
        return v;
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [31:0] v;
        v = $urandom;
        if (v == EBREAK) v = v ^ 32'h1;
        return v;
    endfunction

    task automatic push_halt(input logic [1:0] reason, input logic [63:0] pc, input logic [63:0] code);
        halt_exp_t e;
        e.when_edge = m_cycles;
        e.reason    = reason;
        e.pc        = pc;
        e.code      = code;
        e.instret   = 64'(m_instret);
        e.cycles    = 64'(m_cycles);
        halt_q.push_back(e);
        m_reason = reason;
        m_phase  = 2;
    endtask

    // One clock cycle of stimulus; the model predicts what this cycle's edge does.
    task automatic cyc(input bit iss, input bit cmt, input logic [31:0] inst,
                       input logic [63:0] pc, input logic [63:0] a0);
        issue_fire   = iss;
        commit_valid = cmt;
        commit_inst  = inst;
        commit_pc    = pc;
        a0_value     = a0;
        if (m_phase == 0) begin
            m_cycles++;
            m_infl = clamp(m_infl + int'(iss) - int'(cmt));
            if (cmt) m_instret++;
            if (cmt && inst == EBREAK) begin
                m_pc    = pc;
                m_code  = a0;
                m_phase = 1;
                m_drain = 0;
                flush_q.push_back(m_cycles);
            end else begin
`ifdef HALT_CTRL_WATCHDOG_EN
                m_idle = cmt ? 0 : m_idle + 1;
                if (m_idle == WDOG) push_halt(2'd3, 64'd0, 64'd0);
`endif
            end
        end else if (m_phase == 1) begin
            m_cycles++;
            m_infl = clamp(m_infl - int'(cmt));
            m_drain++;
            if (m_infl == 0)            push_halt((m_code == 0) ? 2'd1 : 2'd2, m_pc, m_code);
            else if (m_drain == DRAIN_MAX) push_halt(2'd3, m_pc, m_code);
        end
        @(posedge clock);
        #1;
        chk("fetch_stall", 64'(fetch_stall), 64'(m_phase != 0));
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 32'h0, 64'h0, 64'h0);
    endtask

    // Idle until the model has halted and the monitor has consumed every event.
    task automatic wait_halt(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (m_phase == 2 && halt_q.size() == 0 && flush_q.size() == 0) break;
            idle_cyc();
        end
        if (halt_q.size() != 0 || flush_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL halt_missing: %0d halt and %0d flush events never seen", halt_q.size(), flush_q.size());
            halt_q.delete();
            flush_q.delete();
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        chk("rst_fetch_stall", 64'(fetch_stall), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_halt_pulse", 64'(halt_pulse), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_reason", 64'(halt_reason), 64'd0);
        chk("rst_pc", halt_pc, 64'd0);
        chk("rst_code", halt_code, 64'd0);
        chk("rst_cycle", cycle_cnt, 64'd0);
        chk("rst_instret", instret_cnt, 64'd0);
        issue_fire = 1'b0;
        commit_valid = 1'b0;
        halt_q.delete();
        flush_q.delete();
        m_phase = 0; m_infl = 0; m_cycles = 0; m_instret = 0;
        m_drain = 0; m_idle = 0; m_pc = '0; m_code = '0; m_reason = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_sticky();
        for (int i = 0; i < 10; i++) begin
            cyc(1'($urandom), 1'($urandom), (i % 3 == 0) ? EBREAK : rnd_inst(),
                {$urandom, $urandom}, {$urandom, $urandom});
        end
        chk("halted_sticky", 64'(halted), 64'd1);
        chk("cycle_frozen", cycle_cnt, 64'(m_cycles));
        chk("instret_frozen", instret_cnt, 64'(m_instret));
        chk("reason_hold", 64'(halt_reason), 64'(m_reason));
    endtask

    // Monitor: compares every flush/halt pulse the DUT presents against the queues.
    halt_exp_t mon_h;
    int        mon_f;
    always @(negedge clock) begin
        if (!reset) begin
            if (flush) begin
                if (flush_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL flush_unexpected: flush=1 at edge %0d, none required", since_rst);
                end else begin
                    mon_f = flush_q.pop_front();
                    chk("flush_edge", 64'(since_rst), 64'(mon_f));
                end
            end
            if (halt_pulse) begin
                if (halt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL halt_unexpected: halt_pulse=1 at edge %0d, none required", since_rst);
                end else begin
                    mon_h = halt_q.pop_front();
                    chk("halt_edge", 64'(since_rst), 64'(mon_h.when_edge));
                    chk("halt_reason", 64'(halt_reason), 64'(mon_h.reason));
                    chk("halt_pc", halt_pc, mon_h.pc);
                    chk("halt_code", halt_code, mon_h.code);
                    chk("instret_cnt", instret_cnt, mon_h.instret);
                    chk("cycle_cnt", cycle_cnt, mon_h.cycles);
                    chk("halted_level", 64'(halted), 64'd1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] pc;
        @(posedge clock);
        #1;

        // 1: ten normal commits, then EBREAK with a0=0 -> GOOD_TRAP, instret 11.
        do_reset();
        pc = 64'h8000_0000;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 64'h0, 64'h0);
            cyc(1'b0, 1'b1, rnd_inst(), pc, 64'($urandom));
            pc += 4;
        end
        cyc(1'b1, 1'b0, 32'h0, 64'h0, 64'h0);
        cyc(1'b0, 1'b1, EBREAK, pc, 64'h0);
        wait_halt(40);
        chk("s1_instret", instret_cnt, 64'd11);
        check_sticky();

        // 2: EBREAK with a0=0x2A and 3 still in flight; drain commits include an EBREAK.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0, 64'h0, 64'h0);
        cyc(1'b0, 1'b1, EBREAK, 64'h8000_1234, 64'h2A);
        cyc(1'b0, 1'b1, EBREAK, 64'h8000_1238, 64'h0);
        cyc(1'b1, 1'b1, rnd_inst(), 64'h8000_123c, 64'h0);
        cyc(1'b0, 1'b1, rnd_inst(), 64'h8000_1240, 64'h0);
        wait_halt(40);
        chk("s2_reason", 64'(halt_reason), 64'd2);

        // 3: five left in flight, nothing commits -> TIMEOUT keeps the EBREAK PC.
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 32'h0, 64'h0, 64'h0);
        cyc(1'b0, 1'b1, EBREAK, 64'h8000_4444, 64'h7);
        wait_halt(40);
        check_sticky();

        // 4a: issue+commit together for 8 cycles and commits at zero leave count at 0.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, rnd_inst(), 64'h100, 64'h0);
        cyc(1'b0, 1'b1, rnd_inst(), 64'h104, 64'h0);
        cyc(1'b0, 1'b1, rnd_inst(), 64'h108, 64'h0);
        cyc(1'b1, 1'b0, 32'h0, 64'h0, 64'h0);
        cyc(1'b0, 1'b1, EBREAK, 64'h10c, 64'h0);
        wait_halt(40);

        // 4b: nine issues saturate at 7, so six drain commits finish the drain.
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 32'h0, 64'h0, 64'h0);
        cyc(1'b0, 1'b1, EBREAK, 64'h200, 64'h55);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, rnd_inst(), 64'h204, 64'h0);
        wait_halt(40);

        // 5: reset asserted in the middle of a drain, then a clean halt.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 64'h0, 64'h0);
        cyc(1'b0, 1'b1, EBREAK, 64'h300, 64'h1);
        idle_cyc();
        do_reset();
        cyc(1'b1, 1'b0, 32'h0, 64'h0, 64'h0);
        cyc(1'b0, 1'b1, EBREAK, 64'h400, 64'h0);
        wait_halt(40);

        // 6: randomized traffic followed by a forced EBREAK and random drain commits.
        for (int t = 0; t < 8; t++) begin
            do_reset();
            pc = {32'h0, $urandom} & ~64'h3;
            for (int i = 0; i < int'($urandom_range(30, 5)); i++) begin
                cyc(1'($urandom), 1'($urandom),
                    ($urandom_range(15, 0) == 0) ? EBREAK : rnd_inst(),
                    pc, ($urandom_range(1, 0) == 0) ? 64'h0 : {$urandom, $urandom});
                pc += 4;
            end
            if (m_phase == 0) begin
                cyc(1'($urandom), 1'b1, EBREAK, pc,
                    ($urandom_range(1, 0) == 0) ? 64'h0 : {$urandom, $urandom});
            end
            for (int i = 0; i < 20 && m_phase != 2; i++) begin
                cyc(1'($urandom), ($urandom_range(2, 0) != 0), rnd_inst(), pc, 64'h0);
            end
            wait_halt(40);
        end

        // 7: a thousand commit-free cycles; only the watchdog build may halt.
        do_reset();
        for (int i = 0; i < 1000; i++) idle_cyc();
        chk("wdog_halted", 64'(halted), 64'(m_phase == 2));
        chk("wdog_cycle_cnt", cycle_cnt, 64'(m_cycles));
        wait_halt(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
